// File: rtl/misc_v_pkg.sv
// misc_v_pkg: shared types for the MISC-V MEM stage.
//   reg_store_t : write-back source select carried from decode
//   mh_state_t  : data-memory handshake FSM states
//   exmem_t     : EX/MEM pipeline register contents
package misc_v_pkg;

  typedef enum logic [1:0] {
    RS_ALU  = 2'b00,
    RS_LOAD = 2'b01,
    RS_PCP2 = 2'b10,
    RS_ALU2 = 2'b11
  } reg_store_t;

  typedef enum logic {
    MH_IDLE,
    MH_BUSY
  } mh_state_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic        mem_read;
    reg_store_t  reg_store;
    logic [15:0] pcp2;
    logic [15:0] alu_result;
    logic [15:0] store_data;
    logic [2:0]  rd;
  } exmem_t;

  // A write wins when both memory bits are set, so a load is read-only.
  function automatic logic is_load(input exmem_t e);
    return e.mem_read & ~e.mem_write;
  endfunction

endpackage

// File: rtl/mem_handshake.sv
// mem_handshake: req/ack sequencer for the data-memory port with a
// timeout that forcibly completes a request nobody acknowledges.
//   clk, reset (async, active low)
//   mem_op   : EX/MEM holds a load or store
//   mem_ack  : memory completed the request this cycle
//   mem_req  : request to memory
//   complete : the current request finishes at the next edge
//   timeout  : completion is forced (no ack) this cycle
//   mem_err  : sticky flag, set at the edge of a forced completion
module mem_handshake
  import misc_v_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic mem_op,
  input  logic mem_ack,
  output logic mem_req,
  output logic complete,
  output logic timeout,
  output logic mem_err
);

  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  mh_state_t     state;
  logic [CW-1:0] cnt;

  always_comb begin
    mem_req  = (state == MH_BUSY) | mem_op;
    timeout  = (state == MH_BUSY) & ~mem_ack & (cnt == CNT_LAST);
    complete = mem_req & (mem_ack | timeout);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= MH_IDLE;
      cnt     <= '0;
      mem_err <= 1'b0;
    end else begin
      case (state)
        MH_IDLE: begin
          if (mem_op && !mem_ack) begin
            state <= MH_BUSY;
            cnt   <= CW'(1);
          end
        end
        MH_BUSY: begin
          if (mem_ack) begin
            state <= MH_IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state   <= MH_IDLE;
            cnt     <= '0;
            mem_err <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= MH_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage of the 16-bit MISC-V core.
// Holds EX/MEM and MEM/WB registers, drives the data-memory req/ack port,
// stalls the front of the pipeline while a memory op is outstanding and
// selects the register write-back value.
//   clk, reset (async, active low)
//   IRegWrite/IMemWrite/IMemRead/IRegStore/IPCP2/IALUResult/I3rdArg/IRd : from EX
//   mem_req/mem_we/mem_addr/mem_wdata/mem_ack/mem_rdata : data-memory port
//   stall                          : freeze IF/ID/EX and EX/MEM
//   ALUResultMEM/ORdMEM/ORegWriteMEM : EX/MEM forwarding view
//   loadDataWB/ORdWB/ORegWriteWB   : MEM/WB write-back / forwarding view
//   mem_err                        : sticky memory timeout flag
module mem_access_stage
  import misc_v_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        IRegWrite,
  input  logic        IMemWrite,
  input  logic        IMemRead,
  input  logic [1:0]  IRegStore,
  input  logic [15:0] IPCP2,
  input  logic [15:0] IALUResult,
  input  logic [15:0] I3rdArg,
  input  logic [2:0]  IRd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        stall,
  output logic [15:0] ALUResultMEM,
  output logic [2:0]  ORdMEM,
  output logic        ORegWriteMEM,
  output logic [15:0] loadDataWB,
  output logic [2:0]  ORdWB,
  output logic        ORegWriteWB,
  output logic        mem_err
);

  exmem_t      exmem;
  logic        mem_op;
  logic        complete;
  logic        timeout;
  logic [15:0] wb_value;

  // EX/MEM register: frozen while the memory op is outstanding.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exmem <= '0;
    end else if (!stall) begin
      exmem.reg_write  <= IRegWrite;
      exmem.mem_write  <= IMemWrite;
      exmem.mem_read   <= IMemRead;
      exmem.reg_store  <= reg_store_t'(IRegStore);
      exmem.pcp2       <= IPCP2;
      exmem.alu_result <= IALUResult;
      exmem.store_data <= I3rdArg;
      exmem.rd         <= IRd;
    end
  end

  assign mem_op = exmem.mem_read | exmem.mem_write;

  mem_handshake #(
    .TIMEOUT(TIMEOUT)
  ) u_handshake (
    .clk     (clk),
    .reset   (reset),
    .mem_op  (mem_op),
    .mem_ack (mem_ack),
    .mem_req (mem_req),
    .complete(complete),
    .timeout (timeout),
    .mem_err (mem_err)
  );

  // Port fields come straight from EX/MEM, so they stay stable while it is held.
  assign mem_we       = exmem.mem_write;
  assign mem_addr     = exmem.alu_result;
  assign mem_wdata    = exmem.store_data;
  assign stall        = mem_req & ~complete;

  assign ALUResultMEM = exmem.alu_result;
  assign ORdMEM       = exmem.rd;
  assign ORegWriteMEM = exmem.reg_write;

  // A load takes memory data (zero on forced completion); any other op picks
  // PC+2 or the ALU result, so RS_LOAD on a non-load falls back to the ALU.
  always_comb begin
    wb_value = exmem.alu_result;
    if (is_load(exmem)) begin
      wb_value = (mem_ack && !timeout) ? mem_rdata : '0;
    end else if (exmem.reg_store == RS_PCP2) begin
      wb_value = exmem.pcp2;
    end
  end

  // MEM/WB register: a stalled cycle injects a bubble by dropping RegWrite only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      loadDataWB  <= '0;
      ORdWB       <= '0;
      ORegWriteWB <= 1'b0;
    end else if (stall) begin
      ORegWriteWB <= 1'b0;
    end else begin
      loadDataWB  <= wb_value;
      ORdWB       <= exmem.rd;
      ORegWriteWB <= exmem.reg_write;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a cycle-level reference model
// of the MEM stage expressed as instruction timeline rules.
module tb_mem_access_stage;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        IRegWrite, IMemWrite, IMemRead;
  logic [1:0]  IRegStore;
  logic [15:0] IPCP2, IALUResult, I3rdArg;
  logic [2:0]  IRd;
  logic        mem_req, mem_we, mem_ack;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        stall;
  logic [15:0] ALUResultMEM;
  logic [2:0]  ORdMEM;
  logic        ORegWriteMEM;
  logic [15:0] loadDataWB;
  logic [2:0]  ORdWB;
  logic        ORegWriteWB;
  logic        mem_err;

  always #5 clk = ~clk;

  mem_access_stage #(
    .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .IRegWrite(IRegWrite), .IMemWrite(IMemWrite), .IMemRead(IMemRead),
    .IRegStore(IRegStore), .IPCP2(IPCP2), .IALUResult(IALUResult),
    .I3rdArg(I3rdArg), .IRd(IRd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall(stall), .ALUResultMEM(ALUResultMEM), .ORdMEM(ORdMEM),
    .ORegWriteMEM(ORegWriteMEM), .loadDataWB(loadDataWB), .ORdWB(ORdWB),
    .ORegWriteWB(ORegWriteWB), .mem_err(mem_err)
  );

  typedef struct packed {
    bit        rw, mw, mr;
    bit [1:0]  rs;
    bit [15:0] pcp2, alu, wd, rdata;
    bit [2:0]  rd;
    int        delay;   // cycles memory waits before acking; 99 = never
  } instr_t;

  instr_t      prog[$];
  instr_t      nop;
  instr_t      cur;      // instruction the model holds in EX/MEM
  int          waited;
  bit          m_err;
  bit [15:0]   m_wb;
  bit [2:0]    m_wbrd;
  bit          m_wbrw;

  int          checks = 0;
  int          errors = 0;
  int          stall_cycles = 0;
  logic [15:0] wb_log[$];

  function automatic instr_t mk(bit rw, bit mw, bit mr, bit [1:0] rs,
                                bit [15:0] pcp2, bit [15:0] alu, bit [15:0] wd,
                                bit [2:0] rd, int delay, bit [15:0] rdata);
    instr_t t;
    t.rw = rw; t.mw = mw; t.mr = mr; t.rs = rs;
    t.pcp2 = pcp2; t.alu = alu; t.wd = wd; t.rd = rd;
    t.delay = delay; t.rdata = rdata;
    return t;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    cur = nop; waited = 0; m_err = 0;
    m_wb = '0; m_wbrd = '0; m_wbrw = 0;
  endtask

  // One clock cycle: drive, compare against the model, advance the model.
  task automatic run_cycle();
    instr_t    nxt;
    bit        memop, ack, tmo, st;
    bit [15:0] wbv;
    @(negedge clk);
    nxt = (prog.size() > 0) ? prog[0] : nop;
    IRegWrite = nxt.rw; IMemWrite = nxt.mw; IMemRead = nxt.mr;
    IRegStore = nxt.rs; IPCP2 = nxt.pcp2; IALUResult = nxt.alu;
    I3rdArg = nxt.wd; IRd = nxt.rd;
    mem_ack   = (waited == cur.delay);
    mem_rdata = cur.rdata;
    #1;
    memop = cur.mr | cur.mw;
    ack   = memop && mem_ack;
    tmo   = memop && !ack && (waited == TO - 1);
    st    = memop && !ack && !tmo;
    chk("mem_req", mem_req, memop);
    chk("mem_we", mem_we, cur.mw);
    chk("mem_addr", mem_addr, cur.alu);
    chk("mem_wdata", mem_wdata, cur.wd);
    chk("stall", stall, st);
    chk("ALUResultMEM", ALUResultMEM, cur.alu);
    chk("ORdMEM", ORdMEM, cur.rd);
    chk("ORegWriteMEM", ORegWriteMEM, cur.rw);
    chk("loadDataWB", loadDataWB, m_wb);
    chk("ORdWB", ORdWB, m_wbrd);
    chk("ORegWriteWB", ORegWriteWB, m_wbrw);
    chk("mem_err", mem_err, m_err);
    if (stall) stall_cycles++;
    if (ORegWriteWB) wb_log.push_back(loadDataWB);
    @(posedge clk);
    if (st) begin
      waited++;
      m_wbrw = 0;
    end else begin
      if (cur.mr && !cur.mw) wbv = ack ? cur.rdata : 16'h0000;
      else if (cur.rs == 2'b10) wbv = cur.pcp2;
      else wbv = cur.alu;
      m_wb = wbv; m_wbrd = cur.rd; m_wbrw = cur.rw;
      if (tmo) m_err = 1;
      waited = 0;
      cur = nxt;
      if (prog.size() > 0) void'(prog.pop_front());
    end
  endtask

  task automatic check_log(input int idx, input logic [15:0] exp);
    if (idx < wb_log.size()) begin
      chk($sformatf("wb_log[%0d]", idx), wb_log[idx], exp);
    end else begin
      checks++;
      errors++;
      $display("FAIL wb_log[%0d] missing (entries=%0d) required=%h", idx, wb_log.size(), exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] exp_log [7];
    exp_log = '{16'h1234, 16'hBEEF, 16'h5A5A, 16'h0000, 16'h0077, 16'h0102, 16'h4321};
    nop = mk(0, 0, 0, 2'b00, 16'h0, 16'h0, 16'h0, 3'd0, 99, 16'h0);
    model_reset();
    reset = 1'b0;
    IRegWrite = 1; IMemWrite = 0; IMemRead = 1; IRegStore = 2'b01;
    IPCP2 = 16'h1111; IALUResult = 16'h2222; I3rdArg = 16'h3333; IRd = 3'd7;
    mem_ack = 1'b1; mem_rdata = 16'hFFFF;

    // Reset state, with non-zero inputs applied across a clock edge.
    #12;
    @(negedge clk); #1;
    chk("rst mem_req", mem_req, 0);
    chk("rst stall", stall, 0);
    chk("rst mem_err", mem_err, 0);
    chk("rst ALUResultMEM", ALUResultMEM, 0);
    chk("rst ORegWriteMEM", ORegWriteMEM, 0);
    chk("rst loadDataWB", loadDataWB, 0);
    chk("rst ORegWriteWB", ORegWriteWB, 0);
    IRegWrite = 0; IMemRead = 0; mem_ack = 0;
    IRegStore = 0; IPCP2 = 0; IALUResult = 0; I3rdArg = 0; IRd = 0; mem_rdata = 0;
    reset = 1'b1;

    //                rw mw mr rs     pcp2     alu      wd       rd  dly rdata
    prog.push_back(mk(1, 0, 0, 2'b00, 16'h0002, 16'h1234, 16'h0000, 3, 99, 16'h0000)); // ALU
    prog.push_back(mk(1, 0, 1, 2'b01, 16'h0004, 16'h0040, 16'h0000, 5, 3,  16'hBEEF)); // load, 3 waits
    prog.push_back(mk(0, 1, 0, 2'b00, 16'h0006, 16'h0010, 16'h00FF, 0, 0,  16'h0000)); // store
    prog.push_back(mk(1, 0, 1, 2'b01, 16'h0008, 16'h0012, 16'h0000, 2, 0,  16'h5A5A)); // load, zero wait
    prog.push_back(mk(1, 0, 1, 2'b01, 16'h000A, 16'h0020, 16'h0000, 4, 99, 16'h0000)); // load, timeout
    prog.push_back(mk(1, 0, 0, 2'b00, 16'h000C, 16'h0077, 16'h0000, 1, 0,  16'hDEAD)); // stray ack
    prog.push_back(mk(1, 0, 0, 2'b10, 16'h0102, 16'h0AAA, 16'h0000, 7, 99, 16'h0000)); // JAL
    prog.push_back(mk(0, 1, 1, 2'b00, 16'h0010, 16'h0030, 16'hA5A5, 0, 1,  16'h0000)); // rd+wr = write
    prog.push_back(mk(1, 0, 0, 2'b11, 16'h0012, 16'h4321, 16'h0000, 6, 99, 16'h0000)); // RS=11 ALU

    for (int i = 0; i < 200 && (prog.size() > 0 || cur.mr || cur.mw); i++) run_cycle();
    checks++;
    if (prog.size() != 0) begin
      errors++;
      $display("FAIL program_drain actual=%0d required=0", prog.size());
    end
    for (int i = 0; i < 3; i++) run_cycle();

    // Literal pins on the DUT history: write-back values in order and total stall.
    for (int i = 0; i < 7; i++) check_log(i, exp_log[i]);
    chk("wb_log_len", 16'(wb_log.size()), 16'd7);
    chk("stall_cycles", 16'(stall_cycles), 16'd7);
    chk("mem_err_sticky", mem_err, 1);

    // Reset while a load is waiting in BUSY.
    prog.push_back(mk(1, 0, 1, 2'b01, 16'h0020, 16'h0050, 16'h0000, 5, 99, 16'h0000));
    for (int i = 0; i < 3; i++) run_cycle();
    chk("pre_rst stall", stall, 1);
    @(negedge clk); #2;
    reset = 1'b0;
    #1;
    chk("midrst mem_req", mem_req, 0);
    chk("midrst stall", stall, 0);
    chk("midrst mem_err", mem_err, 0);
    chk("midrst ALUResultMEM", ALUResultMEM, 0);
    chk("midrst ORegWriteWB", ORegWriteWB, 0);
    prog.delete();
    model_reset();
    IRegWrite = 0; IMemWrite = 0; IMemRead = 0; IRegStore = 0;
    IPCP2 = 0; IALUResult = 0; I3rdArg = 0; IRd = 0; mem_ack = 0;
    @(negedge clk);
    reset = 1'b1;
    wb_log.delete();
    prog.push_back(mk(1, 0, 1, 2'b01, 16'h0030, 16'h0060, 16'h0000, 3, 0, 16'h1111));
    for (int i = 0; i < 4; i++) run_cycle();
    check_log(0, 16'h1111);
    chk("post_rst mem_err", mem_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Pipeline MEM stage of the 16-bit MISC-V core; it consumes the execute stage's outputs and produces the two values the execute stage forwards from: `ALUResultMEM` and `loadDataWB`. It holds the EX/MEM and MEM/WB pipeline registers. It drives a req/ack data-memory port and stalls the front of the pipeline while a load or store is outstanding. It also selects the register write-back value.

## Interface
- `TIMEOUT`, 16: maximum cycles a memory request may wait for `mem_ack` before it is forcibly completed (≥2).
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `IRegWrite`, `IMemWrite`, `IMemRead`  in  1 each  control bits from EX.
- `IRegStore`  in  2  write-back select: 00 ALU result, 01 load data, 10 PC+2, 11 ALU result.
- `IPCP2`, `IALUResult`, `I3rdArg`  in  16 each  PC+2, ALU result, store data.
- `IRd`  in  3  destination register.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  1 = write.
- `mem_addr`, `mem_wdata`  out  16 each  memory address and write data.
- `mem_ack`  in  1  request completed this cycle.
- `mem_rdata`  in  16  read data, valid with `mem_ack`.
- `stall`  out  1  freeze IF/ID/EX and the EX/MEM register.
- `ALUResultMEM`  out  16  EX/MEM ALU result (forward source).
- `ORdMEM`, `ORegWriteMEM`  out  3/1  EX/MEM destination register and write enable, for the forwarding unit.
- `loadDataWB`  out  16  MEM/WB write-back value (forward source and register-file data).
- `ORdWB`, `ORegWriteWB`  out  3/1  register-file write address and enable.
- `mem_err`  out  1  sticky timeout flag.

## Operation
- EX/MEM register holds ctrl, PC+2, ALU result, store data and Rd. It loads EX inputs on each edge where `stall`=0 and holds them while `stall`=1.
- Memory op = EX/MEM MemRead or MemWrite. When both bits are set, the op is a write.
- Port drive:
  - `mem_addr` = EX/MEM ALU result.
  - `mem_wdata` = EX/MEM store data.
  - `mem_we` = EX/MEM MemWrite.
  - All three are stable for as long as `mem_req`=1.
- FSM (`mem_handshake`), states IDLE and BUSY:
  - IDLE: `mem_req` = memory op. If `mem_ack`=1 the op completes with no stall. If memory op and `mem_ack`=0, go to BUSY with cnt=1.
  - BUSY: `mem_req`=1. If `mem_ack`=1, complete and go to IDLE. Otherwise, if cnt==TIMEOUT-1, force completion with read data 0x0000, set `mem_err`, and go to IDLE. Otherwise cnt+1.
  - complete = `mem_ack` or timeout.
  - `stall` = `mem_req` and not complete (combinational).
- `mem_ack` is ignored when `mem_req`=0, including a late ack after a timeout.
- MEM/WB register, on each edge:
  - If `stall`=1, load a bubble (RegWrite=0; Rd and value hold).
  - Otherwise load Rd, RegWrite and the write-back value selected by RegStore.
  - For a load the write-back value is `mem_rdata`, or 0x0000 on timeout.
  - For a store or non-memory op it is the ALU result or PC+2 per RegStore.
- A write never writes the register file unless `IRegWrite` was set by the decoder; this block does not alter RegWrite.

## Timing
- Reset (`reset`=0, asynchronous) clears all registers to 0, FSM to IDLE and cnt to 0. All outputs read 0, including `stall`, `mem_req` and `mem_err`.
- Non-memory instruction: captured into EX/MEM at edge N, so `ALUResultMEM` is valid in cycle N. MEM/WB captures at edge N+1, so `loadDataWB` is valid in cycle N+1.
- Load with zero-wait ack: same latency as a non-memory instruction; `stall` stays 0.
- Load with k wait cycles: `stall`=1 for k cycles. The value reaches MEM/WB at the edge following the ack cycle.
- Timeout: `stall`=1 for exactly TIMEOUT-1 cycles. `mem_err` rises at the completing edge.
- Back-to-back memory ops: the next op drives `mem_req` in the cycle immediately after completion, with no idle cycle.
- Reset mid-request: `mem_req` drops asynchronously and the in-flight op is discarded.

## Structure
- Package `misc_v_pkg`:
  - RegStore encodings (`RS_ALU`, `RS_LOAD`, `RS_PCP2`).
  - FSM state enum (`MH_IDLE`, `MH_BUSY`).
- Sub-module `mem_handshake`: FSM plus timeout counter. Inputs: memory op, `mem_ack`. Outputs: `mem_req`, complete, timeout, `mem_err`.
- Top level holds the EX/MEM and MEM/WB registers and the write-back select.

## Test plan
- ALU op, result 0x1234, Rd=3, RegWrite=1, no memory op → `ALUResultMEM`=0x1234 one cycle after input; `loadDataWB`=0x1234, `ORdWB`=3, `ORegWriteWB`=1 the following cycle; `stall` never 1.
- Load from addr 0x0040, memory acks after 3 cycles with 0xBEEF:
  - `mem_req`=1 and `stall`=1 for 3 cycles, with addr held at 0x0040.
  - `loadDataWB`=0xBEEF after the ack edge.
  - MEM/WB carries RegWrite=0 bubbles during the stall.
- Store of 0x00FF to 0x0010 followed immediately by a zero-wait load from 0x0012 → `mem_we`=1 then 0 in consecutive cycles, with no gap and no stall.
- Load, `mem_ack` held low, TIMEOUT=4:
  - `stall`=1 for 3 cycles.
  - Load value 0x0000, `mem_err`=1 and sticky.
  - A later ack with `mem_req`=0 is ignored.
- JAL-type op with RegStore=10, PC+2=0x0102 → `loadDataWB`=0x0102.
- `reset` pulsed low during BUSY → `mem_req`, `stall` and `mem_err` read 0 immediately; FSM restarts in IDLE.
